data_pulse_rx: RTL and testbench

Serial receiver for the idle-high, LSB-first data-pulse line driven by the team's pulse transmitters. It synchronises the incoming line and detects a low start bit. It then samples DATA_BITS data bits at mid-bit and checks for a high stop bit. Each good frame is presented as a parallel word with a one-cycle valid strobe; each bad frame raises a one-cycle error strobe. It sits at the far end of the pulse link and feeds downstream parallel logic directly; there is no back-pressure.

---
 rtl/data_pulse_rx.sv | 200 ++++++++++++++++++++
 tb/tb_data_pulse_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pulse_rx.sv
// -----------------------------------------------------------------------------
// data_pulse_rx
//
// Receiver for an idle-high, LSB-first data-pulse line. The line is passed
// through a two-flop synchroniser. A low start bit is verified at the middle
// of its bit cell. DATA_BITS data bits are then sampled at mid-bit, followed
// by a high stop bit. A good frame updates data_out with a one-cycle
// data_valid strobe. A low stop bit gives a one-cycle frame_err strobe, and
// the receiver then waits for the line to return high before it will look for
// another start bit. There is no back-pressure.
//
// Parameters
//   DATA_BITS     data bits per frame (1..16)
//   CLKS_PER_BIT  clock cycles per bit cell (1..255)
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   rx_in       serial line (idle high)
//   data_out    last good word, held until the next good frame
//   data_valid  one-cycle pulse when data_out is updated
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   busy        high while a frame is in progress (START/DATA/STOP)
// -----------------------------------------------------------------------------
module data_pulse_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    // Half-cell offset: where the middle of a bit cell falls, measured from
    // the cycle in which the start edge is first seen.
    localparam int H     = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'((H > 0) ? (H - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam bit               H_ZERO   = (H == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic                   s1_q, s2_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic [DATA_BITS-1:0]   shift_ins;

    // LSB first: each new bit enters at the MSB and the word shifts right, so
    // after DATA_BITS samples bit 0 sits at the LSB.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign shift_ins = s2_q;
        end else begin : g_shift_many
            assign shift_ins = {s2_q, shift_q[DATA_BITS-1:1]};
        end
    endgenerate

    // Synchroniser. Both flops reset high so that leaving reset never looks
    // like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rx_in;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!s2_q) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    shift_d = '0;
                    // With no half-cell offset the start bit is verified by
                    // the very sample that detected it.
                    if (H_ZERO) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_START;
                    end
                end
            end

            S_START: begin
                if (cnt_q == H_LAST) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        state_d = S_IDLE;   // glitch: drop silently
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_ins;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_IDLE: begin
                // A line held low (break) reports one error, not a stream.
                if (s2_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_data_pulse_rx.sv
// -----------------------------------------------------------------------------
// tb_data_pulse_rx
//
// Drives two receivers from one line: one with one clock per bit, one with
// four clocks per bit. A reference model predicts every output on every cycle
// from the recorded line history and the frame timing rules (sample edges
// are computed arithmetically from the start-edge cycle). Directed steps add
// explicit checks on latency, spacing and decoded words.
// -----------------------------------------------------------------------------
module tb_data_pulse_rx;

    localparam int MAXN = 16384;
    localparam int C_A  = 1;
    localparam int C_B  = 4;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] a_out, b_out;
    logic       a_valid, b_valid, a_err, b_err, a_busy, b_busy;

    data_pulse_rx #(.DATA_BITS(8), .CLKS_PER_BIT(C_A)) dut_a (
        .clk(clk), .rst(rst), .rx_in(rx),
        .data_out(a_out), .data_valid(a_valid), .frame_err(a_err), .busy(a_busy)
    );

    data_pulse_rx #(.DATA_BITS(8), .CLKS_PER_BIT(C_B)) dut_b (
        .clk(clk), .rst(rst), .rx_in(rx),
        .data_out(b_out), .data_valid(b_valid), .frame_err(b_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;          // index of the next posedge

    logic rx_hist  [MAXN];
    logic rst_hist [MAXN];

    // Reference model state, index 0 = one clock per bit, 1 = four.
    int         mode  [2];        // 0 idle, 1 in frame, 2 waiting for line high
    int         t0    [2];
    logic [7:0] word  [2];
    logic [7:0] e_out [2];
    logic       e_val [2];
    logic       e_err [2];
    logic       e_busy[2];

    // Observed strobe bookkeeping for the directed checks.
    int vcnt [2];
    int ecnt [2];
    int lastv[2];
    int prevv[2];
    int laste[2];

    // Value of the synchronised line that the receiver acts on at edge e.
    function automatic logic line_at(input int e);
        if (e < 2)                              return 1'b1;
        if (rst_hist[e-1] || rst_hist[e-2])     return 1'b1;
        return rx_hist[e-2];
    endfunction

    task automatic model_step(input int k, input int c);
        int   h;
        int   m0;
        int   rel;
        int   b;
        logic ln;
        h = (c - 1) / 2;
        e_val[k] = 1'b0;
        e_err[k] = 1'b0;
        if (rst_hist[n]) begin
            mode[k]   = 0;
            e_out[k]  = 8'h00;
            e_busy[k] = 1'b0;
        end else begin
            ln = line_at(n);
            m0 = mode[k];
            if (m0 == 0 && !ln) begin
                mode[k] = 1;
                t0[k]   = n;
            end
            if (mode[k] == 1 && n >= t0[k] + h) begin
                rel = n - t0[k] - h;
                if (rel == 0) begin
                    if (ln) mode[k] = 0;
                end else if (rel % c == 0) begin
                    b = rel / c;
                    if (b <= 8) begin
                        word[k][b-1] = ln;
                    end else if (ln) begin
                        e_out[k] = word[k];
                        e_val[k] = 1'b1;
                        mode[k]  = 0;
                    end else begin
                        e_err[k] = 1'b1;
                        mode[k]  = 2;
                    end
                end
            end
            if (m0 == 2 && ln) mode[k] = 0;
            e_busy[k] = (mode[k] == 1);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, n - 1, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model past the edge, then sample.
    task automatic tick(input logic r, input logic x);
        rst = r;
        rx  = x;
        @(posedge clk);
        rst_hist[n] = r;
        rx_hist[n]  = x;
        model_step(0, C_A);
        model_step(1, C_B);
        n++;
        #1;
        chk("a_data_out",   {8'h00, a_out},   {8'h00, e_out[0]});
        chk("a_data_valid", {15'h0, a_valid}, {15'h0, e_val[0]});
        chk("a_frame_err",  {15'h0, a_err},   {15'h0, e_err[0]});
        chk("a_busy",       {15'h0, a_busy},  {15'h0, e_busy[0]});
        chk("b_data_out",   {8'h00, b_out},   {8'h00, e_out[1]});
        chk("b_data_valid", {15'h0, b_valid}, {15'h0, e_val[1]});
        chk("b_frame_err",  {15'h0, b_err},   {15'h0, e_err[1]});
        chk("b_busy",       {15'h0, b_busy},  {15'h0, e_busy[1]});
        if (a_valid) begin prevv[0] = lastv[0]; lastv[0] = n - 1; vcnt[0]++; end
        if (b_valid) begin prevv[1] = lastv[1]; lastv[1] = n - 1; vcnt[1]++; end
        if (a_err)   begin laste[0] = n - 1; ecnt[0]++; end
        if (b_err)   begin laste[1] = n - 1; ecnt[1]++; end
        if (n >= MAXN - 2) begin
            $display("FAIL history_overflow at edge %0d", n);
            $fatal(1, "history buffer exhausted");
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b1);
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        return stop;
    endfunction

    // Sends start, 8 data bits LSB first, stop; e = edge capturing the start.
    task automatic send_frame(input int c, input logic [7:0] d, input logic stop, output int e);
        e = n;
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < c; j++) tick(1'b0, frame_bit(d, stop, i));
    endtask

    int e0, e1, e2;
    int v0, er0, v1, er1, r0;
    int kind;
    logic [7:0] rd;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; t0[k] = 0; word[k] = 8'h00; e_out[k] = 8'h00;
            e_val[k] = 1'b0; e_err[k] = 1'b0; e_busy[k] = 1'b0;
            vcnt[k] = 0; ecnt[k] = 0; lastv[k] = -1; prevv[k] = -1; laste[k] = -1;
        end
        rst = 1'b1;
        rx  = 1'b1;

        // Reset, then a single 0x46 frame at one clock per bit.
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("reset_data_out", {8'h00, a_out}, 16'h0000);
        idle(5);
        v0 = vcnt[0]; er0 = ecnt[0];
        send_frame(C_A, 8'h46, 1'b1, e0);
        idle(3);
        chk("f46_word",    {8'h00, a_out}, 16'h0046);
        chk("f46_latency", 16'(lastv[0] - e0), 16'd11);
        chk("f46_count",   16'(vcnt[0] - v0), 16'd1);
        chk("f46_no_err",  16'(ecnt[0] - er0), 16'd0);

        // Back-to-back 0xA5 then 0x3C with no idle gap.
        v0 = vcnt[0];
        send_frame(C_A, 8'hA5, 1'b1, e0);
        send_frame(C_A, 8'h3C, 1'b1, e1);
        idle(3);
        chk("b2b_count",   16'(vcnt[0] - v0), 16'd2);
        chk("b2b_spacing", 16'(lastv[0] - prevv[0]), 16'd10);
        chk("b2b_word",    {8'h00, a_out}, 16'h003C);

        // Bad stop bit, line held low, then a good 0x81.
        v0 = vcnt[0]; er0 = ecnt[0];
        send_frame(C_A, 8'h46, 1'b0, e0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
        chk("bad_stop_keeps_word", {8'h00, a_out}, 16'h003C);
        idle(3);
        send_frame(C_A, 8'h81, 1'b1, e1);
        idle(3);
        chk("bad_stop_err_count", 16'(ecnt[0] - er0), 16'd1);
        chk("bad_stop_err_edge",  16'(laste[0] - e0), 16'd11);
        chk("after_err_word",     {8'h00, a_out}, 16'h0081);
        chk("after_err_valid",    16'(vcnt[0] - v0), 16'd1);

        // Four clocks per bit: one-cycle glitch, then a full 0xC3 frame.
        idle(60);
        v1 = vcnt[1]; er1 = ecnt[1];
        tick(1'b0, 1'b0);
        idle(20);
        chk("glitch_no_valid", 16'(vcnt[1] - v1), 16'd0);
        chk("glitch_no_err",   16'(ecnt[1] - er1), 16'd0);
        send_frame(C_B, 8'hC3, 1'b1, e2);
        idle(8);
        chk("c4_latency", 16'(lastv[1] - e2), 16'd39);
        chk("c4_word",    {8'h00, b_out}, 16'h00C3);

        // Reset during data bit 4 of a frame at one clock per bit.
        idle(60);
        for (int i = 0; i < 10; i++) begin
            tick(i == 5, frame_bit(8'h46, 1'b1, i));
            if (i == 5) begin
                chk("midreset_data_out", {8'h00, a_out}, 16'h0000);
                chk("midreset_busy",     {15'h0, a_busy}, 16'h0000);
                chk("midreset_b_out",    {8'h00, b_out}, 16'h0000);
            end
        end
        idle(30);
        send_frame(C_A, 8'h5A, 1'b1, e0);
        idle(3);
        chk("after_reset_word", {8'h00, a_out}, 16'h005A);

        // Line held low through and after reset.
        idle(60);
        er0 = ecnt[0];
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        r0 = n;
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0);
        chk("low_reset_err_count", 16'(ecnt[0] - er0), 16'd1);
        chk("low_reset_err_edge",  16'(laste[0] - r0), 16'd11);
        idle(60);

        // Randomised traffic at both rates, checked cycle by cycle by the model.
        for (int f = 0; f < 150; f++) begin
            kind = int'($urandom_range(0, 19));
            rd   = 8'($urandom);
            if (kind == 0) begin
                tick(1'b0, 1'b0);                    // glitch
            end else if (kind == 1) begin
                tick(1'b1, 1'($urandom));            // stray reset
            end else begin
                send_frame(($urandom_range(0, 1) == 0) ? C_A : C_B, rd,
                           ($urandom_range(0, 9) != 0), e0);
            end
            idle(int'($urandom_range(0, 12)));
        end
        idle(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
